// File: rtl/ei_tdp_ram_pkg.sv
// ei_tdp_ram_pkg: shared types, default geometry and byte-lane helpers for the TDP RAM
package ei_tdp_ram_pkg;

    typedef enum logic {INIT, RUN} state_e;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int NB             = DEF_DATA_WIDTH / 8;
    localparam int DEPTH          = 2 ** DEF_ADDR_WIDTH;

    // One byte lane of a masked write: the new byte where enabled, else the old one.
    function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                              input logic [7:0] new_byte,
                                              input logic be);
        return be ? new_byte : old_byte;
    endfunction

    // Even-parity bit for one byte lane.
    function automatic logic byte_parity(input logic [7:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/ei_tdp_ram_rd_pipe.sv
// ei_tdp_ram_rd_pipe: per-port read-return delay line (rvalid/rdata/par_err), RD_LATENCY stages
//   clk, resetn           clock, async active-low reset
//   rd_en                 read accepted this cycle
//   rd_data, rd_perr      array word and parity mismatch sampled at the request edge
//   rvalid, rdata, par_err  delayed outputs; rdata holds while rvalid=0, par_err qualified by rvalid
module ei_tdp_ram_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_perr,
    output logic                  rvalid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  par_err
);

    logic [RD_LATENCY-1:0] v;
    logic [RD_LATENCY-1:0] e;
    logic [DATA_WIDTH-1:0] d [RD_LATENCY];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v <= '0;
            e <= '0;
            for (int i = 0; i < RD_LATENCY; i++) d[i] <= '0;
        end else begin
            v[0] <= rd_en;
            e[0] <= rd_en ? rd_perr : e[0];
            d[0] <= rd_en ? rd_data : d[0];
            for (int i = 1; i < RD_LATENCY; i++) begin
                v[i] <= v[i-1];
                e[i] <= v[i-1] ? e[i-1] : e[i];
                d[i] <= v[i-1] ? d[i-1] : d[i];
            end
        end
    end

    assign rvalid  = v[RD_LATENCY-1];
    assign rdata   = d[RD_LATENCY-1];
    assign par_err = v[RD_LATENCY-1] & e[RD_LATENCY-1];

endmodule

// File: rtl/ei_tdp_ram_be_ctrl.sv
// ei_tdp_ram_be_ctrl: true dual-port RAM with byte enables, post-reset clear, ww-collision arbitration
//   clk, resetn                       clock, async active-low reset
//   p_req/p_we/p_be/p_addr/p_wdata    request inputs per port (p = a|b), live only once init_done=1
//   p_rvalid/p_rdata/p_par_err        read return per port after RD_LATENCY cycles
//   init_done                         array clear finished
//   coll_ww                           pulse: both ports wrote the same word in one cycle
//   Optional macro TDP_RAM_PARITY_EN adds one even-parity bit per byte; otherwise p_par_err=0.
module ei_tdp_ram_be_ctrl
    import ei_tdp_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RD_LATENCY = 1,
    parameter int PRIO_A     = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    a_req,
    input  logic                    a_we,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_wdata,
    output logic                    a_rvalid,
    output logic [DATA_WIDTH-1:0]   a_rdata,
    output logic                    a_par_err,
    input  logic                    b_req,
    input  logic                    b_we,
    input  logic [DATA_WIDTH/8-1:0] b_be,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic [DATA_WIDTH-1:0]   b_wdata,
    output logic                    b_rvalid,
    output logic [DATA_WIDTH-1:0]   b_rdata,
    output logic                    b_par_err,
    output logic                    init_done,
    output logic                    coll_ww
);

    localparam int N_BYTES = DATA_WIDTH / 8;
    localparam int N_WORDS = 2 ** ADDR_WIDTH;

    state_e                state, state_n;
    logic [ADDR_WIDTH-1:0] clr_cnt, clr_n;
    logic                  done_n;
    logic                  run, a_wr, b_wr, a_rd, b_rd, coll, a_perr, b_perr;
    logic [N_BYTES-1:0]    a_bee, b_bee;
    logic [DATA_WIDTH-1:0] a_wd, b_wd;
    logic [DATA_WIDTH-1:0] mem [N_WORDS];

    assign run  = state == RUN;
    assign a_wr = run & a_req & a_we;
    assign b_wr = run & b_req & b_we;
    assign a_rd = run & a_req & ~a_we;
    assign b_rd = run & b_req & ~b_we;
    assign coll = a_wr & b_wr & (a_addr == b_addr);

    always_comb begin
        state_n = (!run && &clr_cnt) ? RUN : state;
        clr_n   = run ? clr_cnt : clr_cnt + 1'b1;
        done_n  = run | &clr_cnt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= INIT;
            clr_cnt   <= '0;
            init_done <= 1'b0;
            coll_ww   <= 1'b0;
        end else begin
            state     <= state_n;
            clr_cnt   <= clr_n;
            init_done <= done_n;
            coll_ww   <= coll;
        end
    end

    // On a same-word collision the winner absorbs the loser's bytes wherever its own
    // be bit is clear, and the loser port is silenced, so only one port touches the word.
    always_comb begin
        a_wd  = a_wdata;
        b_wd  = b_wdata;
        a_bee = coll ? ((PRIO_A != 0) ? (a_be | b_be) : '0) : (a_wr ? a_be : '0);
        b_bee = coll ? ((PRIO_A != 0) ? '0 : (a_be | b_be)) : (b_wr ? b_be : '0);
        for (int k = 0; k < N_BYTES; k++) begin
            a_wd[8*k+:8] = (coll && PRIO_A != 0) ? byte_merge(b_wdata[8*k+:8], a_wdata[8*k+:8], a_be[k]) : a_wdata[8*k+:8];
            b_wd[8*k+:8] = (coll && PRIO_A == 0) ? byte_merge(a_wdata[8*k+:8], b_wdata[8*k+:8], b_be[k]) : b_wdata[8*k+:8];
        end
    end

`ifdef TDP_RAM_PARITY_EN
    logic [N_BYTES-1:0] par_mem [N_WORDS];

    always_comb begin
        a_perr = 1'b0;
        b_perr = 1'b0;
        for (int k = 0; k < N_BYTES; k++) begin
            a_perr = a_perr | (par_mem[a_addr][k] ^ byte_parity(mem[a_addr][8*k+:8]));
            b_perr = b_perr | (par_mem[b_addr][k] ^ byte_parity(mem[b_addr][8*k+:8]));
        end
    end

    always_ff @(posedge clk) begin
        if (!run) begin
            mem[clr_cnt]     <= '0;
            par_mem[clr_cnt] <= '0;
        end else begin
            for (int k = 0; k < N_BYTES; k++) begin
                if (a_bee[k]) begin
                    mem[a_addr][8*k+:8] <= a_wd[8*k+:8];
                    par_mem[a_addr][k]  <= byte_parity(a_wd[8*k+:8]);
                end
                if (b_bee[k]) begin
                    mem[b_addr][8*k+:8] <= b_wd[8*k+:8];
                    par_mem[b_addr][k]  <= byte_parity(b_wd[8*k+:8]);
                end
            end
        end
    end
`else
    assign a_perr = 1'b0;
    assign b_perr = 1'b0;

    always_ff @(posedge clk) begin
        if (!run) begin
            mem[clr_cnt] <= '0;
        end else begin
            for (int k = 0; k < N_BYTES; k++) begin
                if (a_bee[k]) mem[a_addr][8*k+:8] <= a_wd[8*k+:8];
                if (b_bee[k]) mem[b_addr][8*k+:8] <= b_wd[8*k+:8];
            end
        end
    end
`endif

    // The array is read combinationally and captured by the pipe at the request edge,
    // which gives read-first behaviour against a same-cycle write from the other port.
    ei_tdp_ram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .RD_LATENCY(RD_LATENCY)) u_pipe_a (
        .clk(clk), .resetn(resetn), .rd_en(a_rd), .rd_data(mem[a_addr]), .rd_perr(a_perr),
        .rvalid(a_rvalid), .rdata(a_rdata), .par_err(a_par_err)
    );

    ei_tdp_ram_rd_pipe #(.DATA_WIDTH(DATA_WIDTH), .RD_LATENCY(RD_LATENCY)) u_pipe_b (
        .clk(clk), .resetn(resetn), .rd_en(b_rd), .rd_data(mem[b_addr]), .rd_perr(b_perr),
        .rvalid(b_rvalid), .rdata(b_rdata), .par_err(b_par_err)
    );

endmodule

// File: tb/tb_ei_tdp_ram_be_ctrl.sv
// tb_ei_tdp_ram_be_ctrl: directed self-checking bench for ei_tdp_ram_be_ctrl (ADDR_WIDTH=4, RD_LATENCY=2, PRIO_A=1)
module tb_ei_tdp_ram_be_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        a_req, a_we, b_req, b_we;
    logic [3:0]  a_be, b_be, a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_rvalid, b_rvalid, a_par_err, b_par_err, init_done, coll_ww;
    logic [31:0] a_rdata, b_rdata;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ei_tdp_ram_be_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RD_LATENCY(LAT), .PRIO_A(1)) dut (
        .clk(clk), .resetn(resetn),
        .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_par_err(a_par_err),
        .b_req(b_req), .b_we(b_we), .b_be(b_be), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_par_err(b_par_err),
        .init_done(init_done), .coll_ww(coll_ww)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rv(input bit p, output logic [31:0] d, output int lat, output logic pe);
        lat = 1;
        while (!(p ? b_rvalid : a_rvalid) && lat < 8) begin
            cyc();
            lat++;
        end
        d  = p ? b_rdata : a_rdata;
        pe = p ? b_par_err : a_par_err;
    endtask

    task automatic rd(input bit p, input logic [3:0] addr, output logic [31:0] d, output int lat, output logic pe);
        if (p) begin b_req = 1; b_we = 0; b_addr = addr; end
        else   begin a_req = 1; a_we = 0; a_addr = addr; end
        cyc();
        a_req = 0;
        b_req = 0;
        wait_rv(p, d, lat, pe);
    endtask

    task automatic wr(input bit p, input logic [3:0] addr, input logic [31:0] d, input logic [3:0] be);
        if (p) begin b_req = 1; b_we = 1; b_addr = addr; b_wdata = d; b_be = be; end
        else   begin a_req = 1; a_we = 1; a_addr = addr; a_wdata = d; a_be = be; end
        cyc();
        a_req = 0;
        b_req = 0;
    endtask

    task automatic wr2(input logic [3:0] aa, input logic [31:0] ad, input logic [3:0] abe,
                       input logic [3:0] ba, input logic [31:0] bd, input logic [3:0] bbe,
                       output logic c);
        a_req = 1; a_we = 1; a_addr = aa; a_wdata = ad; a_be = abe;
        b_req = 1; b_we = 1; b_addr = ba; b_wdata = bd; b_be = bbe;
        cyc();
        a_req = 0;
        b_req = 0;
        c = coll_ww;
    endtask

    initial begin
        logic [31:0] d, acc;
        logic        pe, c, seen;
        int          lat, cnt, first, nv;
        resetn = 0;
        a_req = 0; a_we = 0; a_be = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_be = 0; b_addr = 0; b_wdata = 0;
        repeat (3) @(negedge clk);
        check("rst_init_done", init_done, 0);
        check("rst_a_rvalid", a_rvalid, 0);
        check("rst_coll", coll_ww, 0);
        check("rst_a_rdata", a_rdata, 0);

        // release reset with a read on 0x5 that must be dropped during INIT
        @(negedge clk);
        resetn = 1;
        a_req = 1; a_we = 0; a_addr = 4'h5;
        cnt = 0; seen = 0;
        while (!init_done && cnt < 100) begin
            cyc();
            cnt++;
            a_req = 0;
            seen |= a_rvalid;
        end
        check("init_latency", cnt, 16);
        check("init_drop_read", seen, 0);

        acc = 0;
        for (int i = 0; i < 16; i++) begin
            rd(0, i[3:0], d, lat, pe);
            acc |= d;
            if (i == 0) check("rd_latency", lat, LAT);
        end
        check("init_zero", acc, 0);
        check("par_err_idle", pe, 0);

        wr(0, 4'h3, 32'hAABBCCDD, 4'hF);
        wr(0, 4'h3, 32'h11223344, 4'b0101);
        rd(1, 4'h3, d, lat, pe);
        check("be_merge", d, 32'hAA22CC44);
        check("be_latency", lat, LAT);
        wr(1, 4'h3, 32'hFFFFFFFF, 4'h0);
        rd(0, 4'h3, d, lat, pe);
        check("be_zero_noop", d, 32'hAA22CC44);

        wr2(4'h7, 32'h11111111, 4'hF, 4'h7, 32'h22222222, 4'hF, c);
        check("coll_pulse", c, 1);
        cyc();
        check("coll_once", coll_ww, 0);
        rd(1, 4'h7, d, lat, pe);
        check("coll_winner", d, 32'h11111111);

        wr2(4'h8, 32'h11111111, 4'b0011, 4'h8, 32'h22222222, 4'b0110, c);
        check("coll_part_pulse", c, 1);
        rd(0, 4'h8, d, lat, pe);
        check("coll_part_data", d, 32'h00221111);

        wr2(4'hA, 32'h11111111, 4'b0001, 4'hA, 32'h22222222, 4'b1000, c);
        check("coll_disj_pulse", c, 1);
        rd(0, 4'hA, d, lat, pe);
        check("coll_disj_data", d, 32'h22000011);

        wr2(4'hB, 32'h0B0B0B0B, 4'hF, 4'hC, 32'h0C0C0C0C, 4'hF, c);
        check("diff_no_coll", c, 0);
        rd(0, 4'hB, d, lat, pe);
        check("diff_a_data", d, 32'h0B0B0B0B);
        rd(1, 4'hC, d, lat, pe);
        check("diff_b_data", d, 32'h0C0C0C0C);

        // read-first: B reads 0x9 in the same cycle A writes it
        a_req = 1; a_we = 1; a_addr = 4'h9; a_wdata = 32'hDEADBEEF; a_be = 4'hF;
        b_req = 1; b_we = 0; b_addr = 4'h9;
        cyc();
        a_req = 0;
        b_req = 0;
        wait_rv(1, d, lat, pe);
        check("rf_old", d, 32'h0);
        rd(1, 4'h9, d, lat, pe);
        check("rf_new", d, 32'hDEADBEEF);

        for (int i = 0; i < 8; i++) wr(1, i[3:0], 32'hA5000000 | i, 4'hF);
        first = -1; nv = 0;
        for (int s = 0; s < 11; s++) begin
            a_req = (s < 8); a_we = 0; a_addr = s[3:0];
            cyc();
            if (a_rvalid) begin
                if (first < 0) first = s;
                check("thr_data", a_rdata, 32'hA5000000 | nv);
                nv++;
            end
        end
        a_req = 0;
        check("thr_first", first, LAT - 1);
        check("thr_count", nv, 8);

`ifdef TDP_RAM_PARITY_EN
        dut.par_mem[2][0] = ~dut.par_mem[2][0];
        rd(0, 4'h2, d, lat, pe);
        check("par_flip", pe, 1);
        rd(0, 4'h4, d, lat, pe);
        check("par_clean", pe, 0);
`endif

        // reset with a read in flight
        a_req = 1; a_we = 0; a_addr = 4'h3;
        cyc();
        a_req = 0;
        resetn = 0;
        #1;
        check("mid_rst_rdata", a_rdata, 0);
        check("mid_rst_init_done", init_done, 0);
        seen = 0;
        repeat (3) begin
            cyc();
            seen |= a_rvalid;
        end
        @(negedge clk);
        resetn = 1;
        cnt = 0;
        while (!init_done && cnt < 100) begin
            cyc();
            cnt++;
            seen |= a_rvalid;
        end
        check("mid_rst_no_rvalid", seen, 0);
        check("reinit_latency", cnt, 16);
        rd(0, 4'h3, d, lat, pe);
        check("reinit_cleared", d, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
